// File: rtl/addsub_iter.sv
// Iterative add/subtract unit: WIDTH-bit operands are processed SLICE bits per clock, using a start/done handshake.
// Optional macro SATURATE_EN makes the result saturate (unsigned); when it is undefined the result wraps.
module addsub_iter #(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    generate
        if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
            $error("addsub_iter: WIDTH must be >= 2 and a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             c_q, c_d;
    logic             op_q, op_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    int               base;
    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE:0]   sum;
    logic [WIDTH-1:0] r_new;
    logic [WIDTH-1:0] res_fin;
    logic             cout_raw;
    logic             ovf_raw;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        c_d      = c_q;
        op_d     = op_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        base  = int'(idx_q) * SLICE;
        a_s   = a_q[base +: SLICE];
        b_s   = b_q[base +: SLICE];
        sum   = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, c_q};
        r_new = r_q;
        r_new[base +: SLICE] = sum[SLICE-1:0];

        // b_q is already inverted for subtract, so one expression covers both the add and the subtract overflow cases
        cout_raw = sum[SLICE] ^ op_q;
        ovf_raw  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (r_new[WIDTH-1] != a_q[WIDTH-1]);
`ifdef SATURATE_EN
        res_fin  = cout_raw ? (op_q ? {WIDTH{1'b0}} : {WIDTH{1'b1}}) : r_new;
`else
        res_fin  = r_new;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{op}};
                    op_d    = op;
                    c_d     = op;
                    idx_d   = '0;
                    r_d     = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                r_d   = r_new;
                c_d   = sum[SLICE];
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d  = S_DONE;
                    result_d = res_fin;
                    cout_d   = cout_raw;
                    ovf_d    = ovf_raw;
                    zero_d   = (res_fin == '0);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            c_q      <= 1'b0;
            op_q     <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            c_q      <= c_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_addsub_iter.sv
// Testbench for addsub_iter: a table of directed vectors on the 8/2 instance, then reset-abort, 16/4 and 8/8 sequences.
module tb_addsub_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, op;
    logic [7:0] a, b;
    logic       busy, done, cout, ovf, zero;
    logic [7:0] result;

    logic        w_start, w_op, w_busy, w_done, w_cout, w_ovf, w_zero;
    logic [15:0] w_a, w_b, w_result;

    logic       s_start, s_op, s_busy, s_done, s_cout, s_ovf, s_zero;
    logic [7:0] s_a, s_b, s_result;

    addsub_iter #(.WIDTH(8), .SLICE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf), .zero(zero)
    );

    addsub_iter #(.WIDTH(16), .SLICE(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(w_start), .op(w_op), .a(w_a), .b(w_b),
        .busy(w_busy), .done(w_done), .result(w_result), .cout(w_cout), .ovf(w_ovf), .zero(w_zero)
    );

    addsub_iter #(.WIDTH(8), .SLICE(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
        .busy(s_busy), .done(s_done), .result(s_result), .cout(s_cout), .ovf(s_ovf), .zero(s_zero)
    );

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       co;
        logic       ov;
        logic       zr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where IDLE has just been re-entered, so calls run back-to-back
    task automatic run_op(input logic o, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] er, input logic ec, input logic eo, input logic ez,
                          input int tag);
        int lat;
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; op = ~o; a = ~av; b = 8'h5A;
        chk($sformatf("v%0d busy_calc", tag), 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d latency", tag), 32'(lat), 32'd4);
        chk($sformatf("v%0d result", tag), 32'(result), 32'(er));
        chk($sformatf("v%0d cout", tag), 32'(cout), 32'(ec));
        chk($sformatf("v%0d ovf", tag), 32'(ovf), 32'(eo));
        chk($sformatf("v%0d zero", tag), 32'(zero), 32'(ez));
        @(negedge clk);
        chk($sformatf("v%0d done_width", tag), 32'(done), 32'd0);
        chk($sformatf("v%0d busy_idle", tag), 32'(busy), 32'd0);
        chk($sformatf("v%0d result_hold", tag), 32'(result), 32'(er));
    endtask

    vec_t vt[10];
    int   lat;
    logic seen_done;

    initial begin
        vt[0] = '{1'b0, 8'd15,  8'd10,  8'd25,  1'b0, 1'b0, 1'b0};
`ifdef SATURATE_EN
        vt[1] = '{1'b0, 8'd255, 8'd1,   8'd255, 1'b1, 1'b0, 1'b0};
        vt[2] = '{1'b1, 8'd10,  8'd15,  8'd0,   1'b1, 1'b0, 1'b1};
        vt[6] = '{1'b0, 8'h80,  8'h80,  8'hFF,  1'b1, 1'b1, 1'b0};
        vt[7] = '{1'b1, 8'h7F,  8'hFF,  8'h00,  1'b1, 1'b1, 1'b1};
`else
        vt[1] = '{1'b0, 8'd255, 8'd1,   8'd0,   1'b1, 1'b0, 1'b1};
        vt[2] = '{1'b1, 8'd10,  8'd15,  8'd251, 1'b1, 1'b0, 1'b0};
        vt[6] = '{1'b0, 8'h80,  8'h80,  8'h00,  1'b1, 1'b1, 1'b1};
        vt[7] = '{1'b1, 8'h7F,  8'hFF,  8'h80,  1'b1, 1'b1, 1'b0};
`endif
        vt[3] = '{1'b1, 8'h80,  8'h01,  8'h7F,  1'b0, 1'b1, 1'b0};
        vt[4] = '{1'b0, 8'h7F,  8'h01,  8'h80,  1'b0, 1'b1, 1'b0};
        vt[5] = '{1'b1, 8'd37,  8'd37,  8'd0,   1'b0, 1'b0, 1'b1};
        vt[8] = '{1'b0, 8'h5A,  8'h33,  8'h8D,  1'b0, 1'b1, 1'b0};
        vt[9] = '{1'b1, 8'd200, 8'd100, 8'd100, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        w_start = 1'b0; w_op = 1'b0; w_a = '0; w_b = '0;
        s_start = 1'b0; s_op = 1'b0; s_a = '0; s_b = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst result", 32'(result), 32'd0);
        chk("rst flags", {29'd0, cout, ovf, zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].co, vt[i].ov, vt[i].zr, i);

        // Abort: reset lands on the second CALC edge
        start = 1'b1; op = 1'b1; a = 8'd50; b = 8'd100;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort result", 32'(result), 32'd0);
        chk("abort flags", {29'd0, cout, ovf, zero}, 32'd0);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("abort no_done", 32'(seen_done), 32'd0);
`ifdef SATURATE_EN
        run_op(1'b0, 8'd123, 8'd200, 8'd255, 1'b1, 1'b0, 1'b0, 100);
`else
        run_op(1'b0, 8'd123, 8'd200, 8'd67, 1'b1, 1'b0, 1'b0, 100);
`endif

        w_start = 1'b1; w_op = 1'b0; w_a = 16'd123; w_b = 16'd200;
        @(negedge clk);
        w_start = 1'b0; w_a = 16'hFFFF;
        lat = 0;
        while (!w_done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("w16 latency", 32'(lat), 32'd4);
        chk("w16 result", 32'(w_result), 32'd323);
        chk("w16 cout", 32'(w_cout), 32'd0);
        chk("w16 zero", 32'(w_zero), 32'd0);

        s_start = 1'b1; s_op = 1'b0; s_a = 8'd255; s_b = 8'd255;
        @(negedge clk);
        s_start = 1'b0; s_a = 8'd0;
        lat = 0;
        while (!s_done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("s8 latency", 32'(lat), 32'd1);
`ifdef SATURATE_EN
        chk("s8 result", 32'(s_result), 32'd255);
`else
        chk("s8 result", 32'(s_result), 32'd254);
`endif
        chk("s8 cout", 32'(s_cout), 32'd1);
        chk("s8 ovf", 32'(s_ovf), 32'd0);
        @(negedge clk);
        chk("s8 done_width", 32'(s_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
